// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 instruction-fetch slice.
//  MIPS_NOP      : value presented on the decode bus when nothing is queued
//  WORD_BYTES    : byte stride between consecutive instruction words
//  fetch_state_t : fetch sequencer states
//  ifq_entry_t   : one queued fetch, byte PC plus instruction word
package mips_pkg;

   localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-to-decode handshake bundle.
//  if_valid : queue head is valid
//  if_instr : queue head instruction word
//  if_pc    : byte PC of the queue head
//  if_ready : decode takes the head when if_valid && if_ready
// master = fetch side (drives the head), slave = decode side (drives ready).
interface ifetch_ctrl_if;

   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;

   modport master (
      output if_valid,
      output if_instr,
      output if_pc,
      input  if_ready
   );

   modport slave (
      input  if_valid,
      input  if_instr,
      input  if_pc,
      output if_ready
   );

endinterface

// File: rtl/ifetch_ctrl_ifq_fifo.sv
// Synchronous instruction queue between fetch and decode.
//  clk, rst  : clock, synchronous active-high reset (pointers/count only)
//  push      : enqueue push_data (accepted when not full, or full with a pop)
//  push_data : {pc, instr} entry
//  pop       : dequeue the head (ignored when empty)
//  flush     : discard every entry; overrides push/pop
//  head      : current head entry (contents meaningless while empty)
//  full      : count == DEPTH
//  empty     : count == 0
//  count     : number of queued entries
module ifq_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  ifq_entry_t       push_data,
   input  logic             pop,
   input  logic             flush,
   output ifq_entry_t       head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   ifq_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_eff;
   logic             push_eff;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign pop_eff  = pop && !empty;
   assign push_eff = push && (!full || pop_eff);

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_eff && !pop_eff)      count <= count + CNT_W'(1);
         else if (pop_eff && !push_eff) count <= count - CNT_W'(1);
      end
   end

   // Storage is data only; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_eff) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses the async-read imem and
// queues fetched words toward decode.
//  clk, rst        : clock, synchronous active-high reset
//  imem_addr       : byte address to imem, always equal to the fetch PC
//  imem_instr      : word returned combinationally by imem
//  redirect_valid  : execute requests a PC change (taken branch/jump)
//  redirect_pc     : redirect target, low two bits forced to zero
//  halt_req        : level, suspends new fetches while high
//  dec             : decode handshake (if_valid/if_instr/if_pc out, if_ready in)
//  fetch_fault     : high while the fetch PC has run past the imem
module ifetch_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] MEM_BYTES = 32'd4096
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [31:0]          imem_addr,
   input  logic [31:0]          imem_instr,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   input  logic                 halt_req,
   ifetch_ctrl_if.master        dec,
   output logic                 fetch_fault
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [31:0]      pc;
   logic [31:0]      pc_nxt;
   logic             push;
   logic             flush;
   logic             pop;
   logic             has_space;
   ifq_entry_t       head;
   ifq_entry_t       push_data;
   logic             q_full;
   logic             q_empty;
   logic [CNT_W-1:0] q_count;

   assign pop       = dec.if_valid && dec.if_ready;
   assign has_space = (q_count < CNT_W'(DEPTH)) || (q_full && pop);
   assign push_data = '{pc: pc, instr: imem_instr};

   // Redirect outranks halt, fault and fetch; IDLE ignores it so the first
   // post-reset cycle is always a clean bubble.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      push      = 1'b0;
      flush     = 1'b0;
      if (state != IDLE && redirect_valid) begin
         flush     = 1'b1;
         pc_nxt    = {redirect_pc[31:2], 2'b00};
         state_nxt = halt_req ? HALTED : RUN;
      end else begin
         unique case (state)
            IDLE:   state_nxt = halt_req ? HALTED : RUN;
            RUN: begin
               if (halt_req) begin
                  state_nxt = HALTED;
               end else if (pc >= MEM_BYTES) begin
                  state_nxt = FAULT;
               end else if (has_space) begin
                  push   = 1'b1;
                  pc_nxt = pc + 32'(WORD_BYTES);
               end
            end
            HALTED: if (!halt_req) state_nxt = RUN;
            FAULT:  state_nxt = FAULT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   ifq_fifo #(.DEPTH(DEPTH)) u_ifq (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   // Head fields read as zero while empty so stale storage never leaks to decode.
   assign dec.if_valid = !q_empty;
   assign dec.if_instr = q_empty ? MIPS_NOP : head.instr;
   assign dec.if_pc    = q_empty ? 32'h0 : head.pc;
   assign imem_addr    = pc;
   assign fetch_fault  = (state == FAULT);

endmodule
